// File: rtl/ctrl_pkg.sv
// Shared encodings for the RAM control sequencer: state codes, phases,
// instruction field positions, ALU codes and the boot program.
package ctrl_pkg;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_BOOT_FIRST = 4'd1;
  localparam logic [3:0] ST_BOOT_LAST  = 4'd12;
  localparam logic [3:0] ST_RUN        = 4'd13;
  localparam logic [3:0] ST_HALT       = 4'd14;

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_READ  = 2'd1,
    PH_WRITE = 2'd2
  } phase_t;

  localparam int AADDR_LSB = 12;
  localparam int BADDR_LSB = 8;
  localparam int ALU_LSB   = 5;
  localparam int WADDR_LSB = 1;
  localparam int WE_BIT    = 0;

  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_IMM6 = 3'b110;
  localparam logic [2:0] ALU_IMM7 = 3'b111;

  // Steps 1..6 load register k with immediate k; 7..12 exercise MUL, DIV,
  // the immediate ops and two plain moves (the last one does not write).
  localparam logic [15:0] BOOT_ROM [1:12] = '{
    16'h0103, 16'h0205, 16'h0307, 16'h0409, 16'h050B, 16'h060D,
    16'h124F, 16'h3471, 16'h56D3, 16'h0AF5, 16'h1215, 16'h2318
  };

  function automatic logic is_boot(input logic [3:0] st);
    return (st >= ST_BOOT_FIRST) && (st <= ST_BOOT_LAST);
  endfunction

endpackage

// File: rtl/boot_rom.sv
// Combinational boot program lookup; zero outside the boot steps.
module boot_rom
  import ctrl_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [15:0] word
);

  // Table lookup with a zero default for non-boot indices.
  always_comb begin
    word = 16'h0000;
    if (is_boot(idx)) word = BOOT_ROM[idx];
  end

endmodule

// File: rtl/control_sequencer.sv
// Boot sequencer and instruction fetch/decode front end for the 16x8 RAM.
//
// state  | meaning
// 0      | IDLE, waiting for Start
// 1..12  | BOOT step n, instruction from the boot program
// 13     | RUN, instructions fetched via valid/ready
// 14     | HALTED, waiting for Start
//
// phase  | meaning
// FETCH  | no instruction presented, fields forced to 0
// READ   | fields presented, RAM samples operands
// WRITE  | fields held, Write_Enable may assert, RAM commits result
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK_In,
  input  logic             RST_n,
  input  logic             Start,
  input  logic             Halt,
  input  logic [15:0]      Instr_In,
  input  logic             Instr_Valid,
  output logic             Instr_Ready,
  output logic [3:0]       State,
  output logic [3:0]       Aaddr,
  output logic [3:0]       Baddr,
  output logic [2:0]       Instruction_alu,
  output logic [3:0]       Write_addr,
  output logic             Write_Enable,
  output logic             Busy,
  output logic [CNT_W-1:0] Instr_Count
);

  logic [3:0]       state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [15:0]      instr_q, instr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halt_pend_q, halt_pend_d;
  logic [3:0]       rom_idx;
  logic [15:0]      rom_word;
  logic             ready, accept, fields_en;

  // From IDLE/HALTED the next step is 1, otherwise the step after the current one.
  assign rom_idx = ((state_q == ST_IDLE) || (state_q == ST_HALT)) ? ST_BOOT_FIRST
                                                                  : state_q + 4'd1;

  boot_rom u_boot_rom (
    .idx  (rom_idx),
    .word (rom_word)
  );

  // A halt seen during READ also blocks the accept slot in the following WRITE.
  assign ready  = (state_q == ST_RUN) && !Halt && !halt_pend_q &&
                  ((phase_q == PH_FETCH) || (phase_q == PH_WRITE));
  assign accept = ready && Instr_Valid;

  // State register with async clear.
  always_ff @(posedge CLK_In or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_FETCH;
      instr_q     <= 16'h0000;
      count_q     <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      instr_q     <= instr_d;
      count_q     <= count_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next-state logic for sequencing, handshake, latched instruction and counter.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    instr_d     = instr_q;
    count_d     = count_q;
    halt_pend_d = halt_pend_q;
    if ((state_q == ST_IDLE) || (state_q == ST_HALT)) begin
      if (Start) begin
        state_d     = ST_BOOT_FIRST;
        phase_d     = PH_READ;
        instr_d     = rom_word;
        count_d     = '0;
        halt_pend_d = 1'b0;
      end
    end else if (is_boot(state_q)) begin
      if (phase_q == PH_READ) begin
        phase_d = PH_WRITE;
      end else if (state_q == ST_BOOT_LAST) begin
        state_d = ST_RUN;
        phase_d = PH_FETCH;
        instr_d = 16'h0000;
      end else begin
        state_d = state_q + 4'd1;
        phase_d = PH_READ;
        instr_d = rom_word;
      end
    end else if (state_q == ST_RUN) begin
      if ((phase_q == PH_WRITE) && (count_q != {CNT_W{1'b1}}))
        count_d = count_q + CNT_W'(1);
      if (phase_q == PH_READ) begin
        phase_d = PH_WRITE;
        if (Halt) halt_pend_d = 1'b1;
      end else if (accept) begin
        instr_d = Instr_In;
        phase_d = PH_READ;
      end else if (Halt || halt_pend_q) begin
        state_d     = ST_HALT;
        phase_d     = PH_FETCH;
        instr_d     = 16'h0000;
        halt_pend_d = 1'b0;
      end else begin
        phase_d = PH_FETCH;
        instr_d = 16'h0000;
      end
    end else begin
      state_d     = ST_IDLE;
      phase_d     = PH_FETCH;
      instr_d     = 16'h0000;
      halt_pend_d = 1'b0;
    end
  end

  assign fields_en       = (phase_q != PH_FETCH);
  assign Instr_Ready     = ready;
  assign State           = state_q;
  assign Aaddr           = fields_en ? instr_q[AADDR_LSB +: 4] : 4'h0;
  assign Baddr           = fields_en ? instr_q[BADDR_LSB +: 4] : 4'h0;
  assign Instruction_alu = fields_en ? instr_q[ALU_LSB +: 3]   : 3'b000;
  assign Write_addr      = fields_en ? instr_q[WADDR_LSB +: 4] : 4'h0;
  assign Write_Enable    = instr_q[WE_BIT] && (phase_q == PH_WRITE);
  assign Busy            = (state_q >= ST_BOOT_FIRST) && (state_q <= ST_RUN);
  assign Instr_Count     = count_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Upstream control stage for the 16x8 register-file RAM block.
- Sequences a fixed 12-step boot program, then fetches external 16-bit instructions through a valid/ready handshake.
- Decodes each instruction into the RAM control fields: Aaddr, Baddr, Instruction_alu, Write_addr and Write_Enable.
- Drives the 4-bit State bus the RAM uses to select immediate/boot handling. Each instruction is presented for a READ cycle and then a WRITE cycle.

Parameters:
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- CLK_In  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle pulse; starts boot from IDLE or HALTED.
- Halt  input  1  level; requests stop while in RUN.
- Instr_In  input  16  instruction word from the instruction source.
- Instr_Valid  input  1  Instr_In is valid.
- Instr_Ready  output  1  sequencer accepts Instr_In this cycle.
- State  output  4  0=IDLE, 1..12=BOOT step, 13=RUN, 14=HALTED.
- Aaddr  output  4  Instr[15:12].
- Baddr  output  4  Instr[11:8]; address or immediate.
- Instruction_alu  output  3  Instr[7:5].
- Write_addr  output  4  Instr[4:1].
- Write_Enable  output  1  Instr[0], gated to the WRITE phase.
- Busy  output  1  high in BOOT and RUN.
- Instr_Count  output  CNT_W  retired RUN instructions; saturating.

Behaviour:
- Reset (async, RST_n low): all outputs 0; State=IDLE; phase=FETCH; latched instruction=16'h0000.
  - Reset mid-instruction aborts the instruction; no further Write_Enable is issued.
- Phase FSM, internal: FETCH, READ, WRITE.
  - Fields are registered and held constant across READ and WRITE.
  - Write_Enable = latched Instr[0] AND phase==WRITE.
  - The RAM samples operands at the READ edge and commits the ALU result at the WRITE edge.
- IDLE / HALTED:
  - Fields and Write_Enable are 0; Instr_Ready=0.
  - Start causes State=1, phase=READ on the next cycle.
  - Start in any other state is ignored.
- BOOT (State 1..12):
  - The instruction comes from BOOT_ROM[State].
  - Each step is READ then WRITE, i.e. 2 cycles.
  - After WRITE: State increments; step 12 WRITE moves to State=13, phase FETCH.
  - BOOT_ROM[k] for k=1..6: Aaddr=0, Baddr=k, alu=000, Write_addr=k, WE=1 (loads register k with immediate k).
  - Entries 7..12 are package constants.
  - Halt is ignored during BOOT.
  - Boot total: 24 cycles after the Start edge.
- RUN (State 13):
  - Instr_Ready = !Halt AND (phase==FETCH OR phase==WRITE).
  - Accept occurs when Instr_Valid AND Instr_Ready: latch Instr_In, next phase=READ.
  - An accept during WRITE gives back-to-back instructions at 2 cycles each.
  - At WRITE with no accept, next phase=FETCH.
  - In FETCH, fields are held at 0 and Write_Enable=0.
  - Instr_Count increments at each RUN WRITE cycle and saturates at all-ones. It is cleared when Start is accepted.
- Halt:
  - Sampled in RUN only.
  - If phase==FETCH or WRITE and Halt=1: no accept; next State=HALTED, phase FETCH.
  - Halt asserted during READ: the instruction completes its WRITE, then HALTED.
- ALU ops 010/011: the RAM writes RAM[14]/RAM[15] every cycle these codes are presented. Holding the fields through WRITE guarantees the final value is the valid result.
- Instr_In is ignored when no accept occurs.
- Busy = (State>=1 AND State<=13).

Decomposition:
- Package ctrl_pkg:
  - State codes: ST_IDLE=0, ST_RUN=13, ST_HALT=14.
  - Phase enum.
  - Instruction field bit positions.
  - ALU code constants: MUL=010, DIV=011, IMM6=110, IMM7=111.
  - BOOT_ROM array of 12 x 16-bit entries.
- Sub-module boot_rom: combinational State to 16-bit boot word lookup, returning 0 outside 1..12.
- FSM, handshake and field registers stay in control_sequencer.

Test Plan:
- Reset then Start pulse at edge t -> State=1 with Baddr=1, Write_addr=1 at t+1; Write_Enable=1 only at t+2; State=2 at t+3; State=13, Instr_Ready=1 at t+25.
- In RUN, hold Instr_Valid=1 with Instr_In=16'h1243 then 16'h3405 -> fields A=1, B=2, alu=010, Waddr=1 for 2 cycles, then A=3, B=4, alu=000, Waddr=2; WE high on the 2nd cycle of each; Instr_Count=2.
- Instr_Valid low after one instruction -> phase FETCH: fields 0, WE 0, Instr_Ready stays 1, no count change.
- Assert Halt during READ of 16'h1203 -> WRITE completes with WE=1, then State=14, Instr_Ready=0; Start then gives State=1 and Instr_Count=0.
- Pulse RST_n low during a RUN WRITE -> all outputs 0 immediately (async); State=0; Start required to resume.
- Issue 260 instructions -> Instr_Count saturates at 255; Start pulses during RUN and Halt during BOOT have no effect.
